// File: rtl/result_port_pkg.sv
`default_nettype none
// ============================================================================
// Package     : result_port_pkg
// Description : Constants shared by the result-port writer and the TestBed
//               checker: port address, framing markers, FSM state codes and
//               the write-phase enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package result_port_pkg;

    // Word address of the result port (r30).
    localparam logic [29:0] TEST_PORT = 30'h40;

    // Framing markers that bracket one run on the port.
    localparam logic [31:0] BEGIN_SYM = 32'h0000_0932;
    localparam logic [31:0] END_SYM   = 32'h0000_0D5D;

    // Writer FSM state codes.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Which part of the run the pending write belongs to.
    typedef enum logic [1:0] {
        PH_BEGIN = 2'd0,
        PH_FWD   = 2'd1,
        PH_BWD   = 2'd2,
        PH_END   = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/fib_port_writer_fib_step.sv
`default_nettype none
// ============================================================================
// Module      : fib_step
// Description : Combinational Fibonacci pair update.
//               dir=0 (forward) : (a, b) -> (b, a+b)
//               dir=1 (backward): (a, b) -> (b-a, a)
//               Arithmetic wraps modulo 2^32, so a backward step exactly
//               undoes a forward step even after overflow.
// Ports       : a, b           - current pair (F(k), F(k+1))
//               dir            - 0 forward, 1 backward
//               a_next, b_next - updated pair
// Revision    : 1.0 - initial release
// ============================================================================
module fib_step (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        dir,
    output logic [31:0] a_next,
    output logic [31:0] b_next
);

    assign a_next = dir ? (b - a) : b;
    assign b_next = dir ? a       : (a + b);

endmodule
`default_nettype wire

// File: rtl/fib_port_writer.sv
`default_nettype none
// ============================================================================
// Module      : fib_port_writer
// Description : Result-port initiator. Writes BEGIN_SYM, F(0)..F(N-1),
//               F(N-1)..F(0), END_SYM to TEST_PORT, one write per wen-high
//               period, with a mandatory one-cycle wen-low gap after every
//               accepted write. Honours the data-cache stall handshake.
// Ports       : clk   - clock
//               rst   - asynchronous active-low reset
//               start - begin a run (sampled in IDLE or DONE only)
//               stall - memory stall; holds the pending write
//               addr  - write word address (0 when not writing)
//               data  - write data (0 when not writing)
//               wen   - write enable
//               busy  - high from first write through acceptance of last
//               done  - high in DONE until the next start
// Revision    : 1.0 - initial release
// ============================================================================
module fib_port_writer #(
    parameter int          N         = 30,
    parameter logic [29:0] TEST_PORT = result_port_pkg::TEST_PORT,
    parameter logic [31:0] BEGIN_SYM = result_port_pkg::BEGIN_SYM,
    parameter logic [31:0] END_SYM   = result_port_pkg::END_SYM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done
);

    import result_port_pkg::*;

    localparam int                IDX_W    = $clog2(N + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    logic [1:0]       state;
    phase_t           phase;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [IDX_W-1:0] idx;

    logic [31:0]      a_next;
    logic [31:0]      b_next;
    logic             last_term;

    assign last_term = (idx == LAST_IDX);

    fib_step u_fib_step (
        .a      (a),
        .b      (b),
        .dir    (phase == PH_BWD),
        .a_next (a_next),
        .b_next (b_next)
    );

    // busy doubles as the "more writes to come" flag: it drops when the END
    // write is accepted, which steers the following GAP into DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            phase <= PH_BEGIN;
            a     <= 32'd0;
            b     <= 32'd1;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_WRITE;
                        phase <= PH_BEGIN;
                        a     <= 32'd0;
                        b     <= 32'd1;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!stall) begin
                        state <= ST_GAP;
                        case (phase)
                            PH_BEGIN: phase <= PH_FWD;
                            PH_FWD: begin
                                if (last_term) begin
                                    // Keep the pair so F(N-1) is emitted
                                    // again as the first backward term.
                                    phase <= PH_BWD;
                                    idx   <= '0;
                                end else begin
                                    a   <= a_next;
                                    b   <= b_next;
                                    idx <= idx + 1'b1;
                                end
                            end
                            PH_BWD: begin
                                if (last_term) begin
                                    phase <= PH_END;
                                end else begin
                                    a   <= a_next;
                                    b   <= b_next;
                                    idx <= idx + 1'b1;
                                end
                            end
                            PH_END:  busy  <= 1'b0;
                            default: phase <= PH_BEGIN;
                        endcase
                    end
                end
                ST_GAP:  state <= busy ? ST_WRITE : ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state; no path from stall or start.
    assign wen  = (state == ST_WRITE);
    assign done = (state == ST_DONE);
    assign addr = wen ? TEST_PORT : 30'd0;

    always_comb begin
        data = 32'd0;
        if (wen) begin
            case (phase)
                PH_BEGIN: data = BEGIN_SYM;
                PH_FWD:   data = a;
                PH_BWD:   data = a;
                PH_END:   data = END_SYM;
                default:  data = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fib_port_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_port_writer
// Description : Self-checking bench for fib_port_writer. Three instances
//               (N=30, N=1, N=50) share one clock; a negedge monitor records
//               every accepted write and flags handshake violations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_port_writer;

    logic        clk;
    logic        rn [3];
    logic        st [3];
    logic        sl [3];
    logic [29:0] ad [3];
    logic [31:0] dt [3];
    logic        we [3];
    logic        bz [3];
    logic        dn [3];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [31:0] cap [3][1024];
    int          acc [3]      = '{0, 0, 0};
    logic        held [3]     = '{0, 0, 0};
    logic [31:0] hold_d [3];
    logic        prev_acc [3] = '{0, 0, 0};
    int gap_err   = 0;
    int quiet_err = 0;
    int addr_err  = 0;
    int stab_err  = 0;

    int smode = 0;
    int sbase = 0;
    int na    = 0;
    int nb    = 0;

    fib_port_writer #(.N(30)) u_dut30 (
        .clk(clk), .rst(rn[0]), .start(st[0]), .stall(sl[0]),
        .addr(ad[0]), .data(dt[0]), .wen(we[0]), .busy(bz[0]), .done(dn[0]));

    fib_port_writer #(.N(1)) u_dut1 (
        .clk(clk), .rst(rn[1]), .start(st[1]), .stall(sl[1]),
        .addr(ad[1]), .data(dt[1]), .wen(we[1]), .busy(bz[1]), .done(dn[1]));

    fib_port_writer #(.N(50)) u_dut50 (
        .clk(clk), .rst(rn[2]), .start(st[2]), .stall(sl[2]),
        .addr(ad[2]), .data(dt[2]), .wen(we[2]), .busy(bz[2]), .done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stall driver for the N=30 instance.
    // mode 1: 3 stall cycles on write #5, 1 on the END write.
    // mode 2: stall held from the 7th write onward (FWD phase).
    always @(posedge clk) begin
        int k;
        #1;
        sl[1] = 1'b0;
        sl[2] = 1'b0;
        k = acc[0] - sbase;
        case (smode)
            1: begin
                if (we[0] && k == 4 && na < 3) begin
                    sl[0] = 1'b1; na++;
                end else if (we[0] && k == 61 && nb < 1) begin
                    sl[0] = 1'b1; nb++;
                end else begin
                    sl[0] = 1'b0;
                end
            end
            2:       sl[0] = we[0] && (k >= 6);
            default: begin sl[0] = 1'b0; na = 0; nb = 0; end
        endcase
    end

    // Write monitor: a write presented with stall low at this negedge is
    // accepted on the next posedge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i] === 1'b1) begin
                if (ad[i] !== 30'h40) addr_err++;
                if (prev_acc[i]) gap_err++;
                if (held[i] && dt[i] !== hold_d[i]) stab_err++;
                if (sl[i] === 1'b1) begin
                    held[i]     = 1'b1;
                    hold_d[i]   = dt[i];
                    prev_acc[i] = 1'b0;
                end else begin
                    held[i] = 1'b0;
                    if (acc[i] < 1024) cap[i][acc[i]] = dt[i];
                    acc[i]++;
                    prev_acc[i] = 1'b1;
                end
            end else begin
                held[i]     = 1'b0;
                prev_acc[i] = 1'b0;
                if (ad[i] !== 30'd0 || dt[i] !== 32'd0) quiet_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i, output int c0);
        st[i] = 1'b1;
        @(posedge clk);
        #1;
        st[i] = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int i, input int c0, input int exp, input string tag);
        for (int k = 0; k < 3000; k++) begin
            if (dn[i] === 1'b1) break;
            tick();
        end
        check(tag, 64'(cyc - c0), 64'(exp));
    endtask

    // Expected stream built from a plain 32-bit forward recurrence.
    task automatic compare_run(input int i, input int base, input int n, input string tag);
        logic [31:0] f [64];
        logic [31:0] x, y, t;
        x = 32'd0;
        y = 32'd1;
        for (int k = 0; k < n; k++) begin
            f[k] = x;
            t = x + y;
            x = y;
            y = t;
        end
        check({tag, "_count"}, 64'(acc[i] - base), 64'(2 * n + 2));
        check({tag, "_begin"}, 64'(cap[i][base]), 64'h932);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_fwd%0d", tag, k), 64'(cap[i][base + 1 + k]), 64'(f[k]));
        for (int k = 0; k < n; k++)
            check($sformatf("%s_bwd%0d", tag, k), 64'(cap[i][base + 1 + n + k]), 64'(f[n - 1 - k]));
        check({tag, "_end"}, 64'(cap[i][base + 2 * n + 1]), 64'hD5D);
    endtask

    initial begin
        int c0;
        int base;
        for (int i = 0; i < 3; i++) begin
            rn[i] = 1'b0;
            st[i] = 1'b0;
        end
        repeat (3) tick();

        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_wen%0d", i),  64'(we[i]), 64'd0);
            check($sformatf("rst_addr%0d", i), 64'(ad[i]), 64'd0);
            check($sformatf("rst_data%0d", i), 64'(dt[i]), 64'd0);
            check($sformatf("rst_busy%0d", i), 64'(bz[i]), 64'd0);
            check($sformatf("rst_done%0d", i), 64'(dn[i]), 64'd0);
        end
        for (int i = 0; i < 3; i++) rn[i] = 1'b1;
        repeat (2) tick();
        check("idle_done", 64'(dn[0]), 64'd0);

        // Run A: N=30, no stall, spurious start mid-run.
        base = acc[0];
        pulse(0, c0);
        check("A_first_wen",  64'(we[0]), 64'd1);
        check("A_first_data", 64'(dt[0]), 64'h932);
        check("A_busy",       64'(bz[0]), 64'd1);
        repeat (20) tick();
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        wait_done(0, c0, 124, "A_done_cycles");
        check("A_busy_after", 64'(bz[0]), 64'd0);
        compare_run(0, base, 30, "A");
        check("A_F29_fwd", 64'(cap[0][base + 30]), 64'd514229);
        check("A_F29_bwd", 64'(cap[0][base + 31]), 64'd514229);

        // Run B: restart from DONE with stalls on write #5 and END.
        smode = 1;
        base  = acc[0];
        sbase = acc[0];
        pulse(0, c0);
        wait_done(0, c0, 128, "B_done_cycles");
        smode = 0;
        compare_run(0, base, 30, "B");

        // Reset while stalled in FWD, then a clean run.
        smode = 2;
        sbase = acc[0];
        pulse(0, c0);
        for (int k = 0; k < 200; k++) begin
            if (sl[0] === 1'b1) break;
            tick();
        end
        repeat (2) tick();
        check("R_wen_before", 64'(we[0]), 64'd1);
        #2;
        rn[0] = 1'b0;
        #1;
        check("R_wen",  64'(we[0]), 64'd0);
        check("R_addr", 64'(ad[0]), 64'd0);
        check("R_data", 64'(dt[0]), 64'd0);
        check("R_busy", 64'(bz[0]), 64'd0);
        smode = 0;
        tick();
        rn[0] = 1'b1;
        tick();
        base = acc[0];
        pulse(0, c0);
        wait_done(0, c0, 124, "R_done_cycles");
        compare_run(0, base, 30, "R");

        // N=1.
        base = acc[1];
        pulse(1, c0);
        wait_done(1, c0, 8, "N1_done_cycles");
        compare_run(1, base, 1, "N1");

        // N=50, values past F(47) wrap modulo 2^32.
        base = acc[2];
        pulse(2, c0);
        wait_done(2, c0, 204, "N50_done_cycles");
        compare_run(2, base, 50, "N50");
        check("N50_F47", 64'(cap[2][base + 48]), 64'd2971215073);

        check("gap_violations",   64'(gap_err),   64'd0);
        check("quiet_violations", 64'(quiet_err), 64'd0);
        check("addr_violations",  64'(addr_err),  64'd0);
        check("stall_stability",  64'(stab_err),  64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
